// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage.
// Registers the execute-stage instruction for the memory stage, resolves
// taken branches/jumps into a one-cycle fetch redirect, squashes the
// wrong-path instruction that sits in EX during the redirect cycle, and
// exposes forwarding / load-pending status to the hazard unit.
module exmem_stage #(
    parameter int DW   = 16,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [DW-1:0]   alu_result,
    input  logic [DW-1:0]   pc_target,
    input  logic [DW-1:0]   pc_plus_2,
    input  logic [DW-1:0]   store_data,
    input  logic            branch,
    input  logic            jmp,
    input  logic            link,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [2:0]      dest_reg,
    input  logic            reg_wr,
    input  logic            mem_stall,
    output logic            ex_stall,
    output logic            exmem_valid,
    output logic [DW-1:0]   exmem_result,
    output logic [DW-1:0]   exmem_store_data,
    output logic            exmem_mem_rd,
    output logic            exmem_mem_wr,
    output logic [2:0]      exmem_dest_reg,
    output logic            exmem_reg_wr,
    output logic            redirect,
    output logic [DW-1:0]   redirect_pc,
    output logic            fwd_valid,
    output logic            load_pending,
    output logic [CNTW-1:0] taken_cnt
);

    logic taken;
    logic accept;
    logic take_redirect;

    // Control-flow resolution; an instruction in EX while redirect is high is wrong-path.
    always_comb begin
        taken         = jmp | (branch & alu_result[0]);
        accept        = ex_valid & ~mem_stall & ~redirect;
        take_redirect = accept & taken;
    end

    assign ex_stall     = mem_stall;
    assign fwd_valid    = exmem_valid & exmem_reg_wr & ~exmem_mem_rd;
    assign load_pending = exmem_valid & exmem_mem_rd;

    // EX/MEM pipeline register: hold on stall, capture on accept, otherwise bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_valid      <= 1'b0;
            exmem_result     <= '0;
            exmem_store_data <= '0;
            exmem_mem_rd     <= 1'b0;
            exmem_mem_wr     <= 1'b0;
            exmem_dest_reg   <= '0;
            exmem_reg_wr     <= 1'b0;
        end else if (!mem_stall) begin
            if (accept) begin
                exmem_valid      <= 1'b1;
                exmem_result     <= link ? pc_plus_2 : alu_result;
                exmem_store_data <= store_data;
                exmem_mem_rd     <= mem_rd;
                exmem_mem_wr     <= mem_wr;
                exmem_dest_reg   <= dest_reg;
                exmem_reg_wr     <= reg_wr;
            end else begin
                // Bubble: kill the side-effect controls, leave data fields as they were.
                exmem_valid  <= 1'b0;
                exmem_mem_rd <= 1'b0;
                exmem_mem_wr <= 1'b0;
                exmem_reg_wr <= 1'b0;
            end
        end
    end

    // Redirect pulse, target and taken counter; updated every edge, independent of the stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
            taken_cnt   <= '0;
        end else begin
            redirect <= take_redirect;
            if (take_redirect) begin
                redirect_pc <= pc_target;
                taken_cnt   <= taken_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed vector table, hand-written
// stall / async-reset / counter-wrap sequences, then randomized traffic
// checked against a behavioural model of the stage.
module tb_exmem_stage;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          ex_valid, branch, jmp, link, mem_rd, mem_wr, reg_wr, mem_stall;
    logic [DW-1:0] alu_result, pc_target, pc_plus_2, store_data;
    logic [2:0]    dest_reg;

    logic          ex_stall, exmem_valid, exmem_mem_rd, exmem_mem_wr, exmem_reg_wr;
    logic          redirect, fwd_valid, load_pending;
    logic [DW-1:0] exmem_result, exmem_store_data, redirect_pc;
    logic [2:0]    exmem_dest_reg;
    logic [15:0]   taken_cnt;

    logic          c4_ex_stall, c4_valid, c4_mem_rd, c4_mem_wr, c4_reg_wr;
    logic          c4_redirect, c4_fwd_valid, c4_load_pending;
    logic [DW-1:0] c4_result, c4_store_data, c4_redirect_pc;
    logic [2:0]    c4_dest_reg;
    logic [3:0]    c4_taken_cnt;

    exmem_stage #(.DW(DW), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
        .pc_target(pc_target), .pc_plus_2(pc_plus_2), .store_data(store_data),
        .branch(branch), .jmp(jmp), .link(link), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .dest_reg(dest_reg), .reg_wr(reg_wr), .mem_stall(mem_stall),
        .ex_stall(ex_stall), .exmem_valid(exmem_valid), .exmem_result(exmem_result),
        .exmem_store_data(exmem_store_data), .exmem_mem_rd(exmem_mem_rd),
        .exmem_mem_wr(exmem_mem_wr), .exmem_dest_reg(exmem_dest_reg),
        .exmem_reg_wr(exmem_reg_wr), .redirect(redirect), .redirect_pc(redirect_pc),
        .fwd_valid(fwd_valid), .load_pending(load_pending), .taken_cnt(taken_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for wrap checks.
    exmem_stage #(.DW(DW), .CNTW(4)) u_cnt4 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
        .pc_target(pc_target), .pc_plus_2(pc_plus_2), .store_data(store_data),
        .branch(branch), .jmp(jmp), .link(link), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .dest_reg(dest_reg), .reg_wr(reg_wr), .mem_stall(mem_stall),
        .ex_stall(c4_ex_stall), .exmem_valid(c4_valid), .exmem_result(c4_result),
        .exmem_store_data(c4_store_data), .exmem_mem_rd(c4_mem_rd),
        .exmem_mem_wr(c4_mem_wr), .exmem_dest_reg(c4_dest_reg),
        .exmem_reg_wr(c4_reg_wr), .redirect(c4_redirect), .redirect_pc(c4_redirect_pc),
        .fwd_valid(c4_fwd_valid), .load_pending(c4_load_pending), .taken_cnt(c4_taken_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The stage is viewed as one "slot" holding the last retired instruction,
    // plus a record of redirects issued so far.
    typedef struct {
        bit          valid;
        bit [DW-1:0] result;
        bit [DW-1:0] sdata;
        bit          rd;
        bit          wr;
        bit [2:0]    dest;
        bit          rw;
    } slot_t;

    slot_t       m_slot;
    bit          m_redirect;
    bit [DW-1:0] m_rpc;
    int unsigned m_redirects;

    task automatic model_reset();
        m_slot      = '{default: 0};
        m_redirect  = 0;
        m_rpc       = '0;
        m_redirects = 0;
    endtask

    // One clock edge: the instruction in EX retires if it is real, the memory
    // stage is free and it is not on the wrong path behind a redirect.
    task automatic model_step();
        bit retire;
        bit is_taken;
        retire   = ex_valid && !mem_stall && !m_redirect;
        is_taken = jmp || (branch && alu_result[0]);
        if (retire) begin
            m_slot = '{1, (link ? pc_plus_2 : alu_result), store_data, mem_rd, mem_wr,
                       dest_reg, reg_wr};
        end else if (!mem_stall) begin
            m_slot.valid = 0;
            m_slot.rd    = 0;
            m_slot.wr    = 0;
            m_slot.rw    = 0;
        end
        m_redirect = retire && is_taken;
        if (m_redirect) begin
            m_rpc = pc_target;
            m_redirects++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},    exmem_valid,      m_slot.valid);
        chk({tag, ".result"},   exmem_result,     m_slot.result);
        chk({tag, ".sdata"},    exmem_store_data, m_slot.sdata);
        chk({tag, ".mem_rd"},   exmem_mem_rd,     m_slot.rd);
        chk({tag, ".mem_wr"},   exmem_mem_wr,     m_slot.wr);
        chk({tag, ".dest"},     exmem_dest_reg,   m_slot.dest);
        chk({tag, ".reg_wr"},   exmem_reg_wr,     m_slot.rw);
        chk({tag, ".redirect"}, redirect,         m_redirect);
        chk({tag, ".rpc"},      redirect_pc,      m_rpc);
        chk({tag, ".fwd"},      fwd_valid,        m_slot.valid && m_slot.rw && !m_slot.rd);
        chk({tag, ".ldpend"},   load_pending,     m_slot.valid && m_slot.rd);
        chk({tag, ".ex_stall"}, ex_stall,         mem_stall);
        chk({tag, ".cnt"},      taken_cnt,        m_redirects % 65536);
        chk({tag, ".cnt4"},     c4_taken_cnt,     m_redirects % 16);
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        ex_valid = 0; branch = 0; jmp = 0; link = 0; mem_rd = 0; mem_wr = 0;
        reg_wr = 0; mem_stall = 0; dest_reg = '0;
        alu_result = '0; pc_target = '0; pc_plus_2 = '0; store_data = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"},  exmem_valid,  0);
        chk({tag, ".result"}, exmem_result, 0);
        chk({tag, ".sdata"},  exmem_store_data, 0);
        chk({tag, ".rd"},     exmem_mem_rd, 0);
        chk({tag, ".wr"},     exmem_mem_wr, 0);
        chk({tag, ".dest"},   exmem_dest_reg, 0);
        chk({tag, ".rw"},     exmem_reg_wr, 0);
        chk({tag, ".redir"},  redirect,     0);
        chk({tag, ".rpc"},    redirect_pc,  0);
        chk({tag, ".fwd"},    fwd_valid,    0);
        chk({tag, ".ldp"},    load_pending, 0);
        chk({tag, ".cnt"},    taken_cnt,    0);
        chk({tag, ".cnt4"},   c4_taken_cnt, 0);
        chk({tag, ".c4val"},  c4_valid,     0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        bit          ev, br, jp, lk, rd, wr, rw;
        bit [DW-1:0] alu, tgt, pc2, sd;
        bit [2:0]    dst;
        bit          e_valid;
        bit [DW-1:0] e_result;
        bit [2:0]    e_dest;
        bit          e_redirect;
        bit [DW-1:0] e_rpc;
        bit [15:0]   e_cnt;
        bit          e_fwd, e_ld;
    } vec_t;

    function automatic vec_t mk(string nm, bit ev, bit br, bit jp, bit lk, bit rd, bit wr,
                                bit rw, bit [DW-1:0] alu, bit [DW-1:0] tgt, bit [DW-1:0] pc2,
                                bit [DW-1:0] sd, bit [2:0] dst, bit e_valid,
                                bit [DW-1:0] e_result, bit [2:0] e_dest, bit e_redirect,
                                bit [DW-1:0] e_rpc, bit [15:0] e_cnt, bit e_fwd, bit e_ld);
        vec_t v;
        v = '{nm, ev, br, jp, lk, rd, wr, rw, alu, tgt, pc2, sd, dst,
              e_valid, e_result, e_dest, e_redirect, e_rpc, e_cnt, e_fwd, e_ld};
        return v;
    endfunction

    vec_t tbl[10];

    task automatic apply_vec(input vec_t v);
        set_idle();
        ex_valid = v.ev; branch = v.br; jmp = v.jp; link = v.lk; mem_rd = v.rd;
        mem_wr = v.wr; reg_wr = v.rw; alu_result = v.alu; pc_target = v.tgt;
        pc_plus_2 = v.pc2; store_data = v.sd; dest_reg = v.dst;
        tick();
        chk({v.name, ".valid"},  exmem_valid,    v.e_valid);
        chk({v.name, ".result"}, exmem_result,   v.e_result);
        chk({v.name, ".dest"},   exmem_dest_reg, v.e_dest);
        chk({v.name, ".redir"},  redirect,       v.e_redirect);
        chk({v.name, ".rpc"},    redirect_pc,    v.e_rpc);
        chk({v.name, ".cnt"},    taken_cnt,      v.e_cnt);
        chk({v.name, ".fwd"},    fwd_valid,      v.e_fwd);
        chk({v.name, ".ldp"},    load_pending,   v.e_ld);
        check_model(v.name);
    endtask

    initial begin
        //            name       ev br jp lk rd wr rw alu      tgt      pc2      sd       dst   vld res      dst rdr rpc      cnt fwd ld
        tbl[0] = mk("add",       1, 0, 0, 0, 0, 0, 1, 16'h0042, 16'h0000, 16'h0004, 16'h0000, 3, 1, 16'h0042, 3, 0, 16'h0000, 1'b0 ? 16'd0 : 16'd0, 1, 0);
        tbl[1] = mk("beqz_tk",   1, 1, 0, 0, 0, 0, 0, 16'h0001, 16'h0100, 16'h0006, 16'h0000, 0, 1, 16'h0001, 0, 1, 16'h0100, 16'd1, 0, 0);
        tbl[2] = mk("squash1",   1, 0, 0, 0, 0, 0, 1, 16'h0055, 16'h0000, 16'h0008, 16'h0000, 2, 0, 16'h0001, 0, 0, 16'h0100, 16'd1, 0, 0);
        tbl[3] = mk("bnez_nt",   1, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0300, 16'h0102, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0100, 16'd1, 0, 0);
        tbl[4] = mk("jal",       1, 0, 1, 1, 0, 0, 1, 16'h1234, 16'h0200, 16'h0012, 16'h0000, 7, 1, 16'h0012, 7, 1, 16'h0200, 16'd2, 1, 0);
        tbl[5] = mk("squash_j",  1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0400, 16'h0014, 16'h0000, 0, 0, 16'h0012, 7, 0, 16'h0200, 16'd2, 0, 0);
        tbl[6] = mk("idle",      0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0012, 7, 0, 16'h0200, 16'd2, 0, 0);
        tbl[7] = mk("store",     1, 0, 0, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0202, 16'hBEEF, 1, 1, 16'h0010, 1, 0, 16'h0200, 16'd2, 0, 0);
        tbl[8] = mk("br_and_j",  1, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h0600, 16'h0204, 16'h0000, 0, 1, 16'h0000, 0, 1, 16'h0600, 16'd3, 0, 0);
        tbl[9] = mk("idle2",     0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0600, 16'd3, 0, 0);

        // Reset state
        set_idle();
        model_reset();
        rst = 1'b1;
        #12;
        check_all_zero("reset");
        rst = 1'b0;

        foreach (tbl[i]) apply_vec(tbl[i]);

        // Load then a three-cycle memory stall; a jump offered during the stall must not be taken.
        set_idle();
        ex_valid = 1; mem_rd = 1; reg_wr = 1; dest_reg = 3'd4; alu_result = 16'h0080;
        tick();
        chk("ld.valid", exmem_valid, 1);
        chk("ld.ldp", load_pending, 1);
        chk("ld.fwd", fwd_valid, 0);
        check_model("ld");
        set_idle();
        ex_valid = 1; jmp = 1; pc_target = 16'h0500; mem_stall = 1;
        for (int c = 0; c < 3; c++) begin
            chk("stall.ex_stall_pre", ex_stall, 1);
            tick();
            chk("stall.valid", exmem_valid, 1);
            chk("stall.result", exmem_result, 16'h0080);
            chk("stall.ldp", load_pending, 1);
            chk("stall.redir", redirect, 0);
            chk("stall.cnt", taken_cnt, 3);
            check_model("stall");
        end
        set_idle();
        tick();
        chk("unstall.valid", exmem_valid, 0);
        chk("unstall.ldp", load_pending, 0);
        check_model("unstall");

        // Asynchronous reset while a taken jump is in EX/MEM and redirect is high.
        set_idle();
        ex_valid = 1; jmp = 1; link = 1; reg_wr = 1; dest_reg = 3'd5;
        pc_plus_2 = 16'h0030; pc_target = 16'h0700;
        tick();
        chk("pre_rst.valid", exmem_valid, 1);
        chk("pre_rst.redir", redirect, 1);
        set_idle();
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        rst = 1'b0;

        // Counter wrap on the 4-bit instance after 16 redirects.
        for (int n = 1; n <= 16; n++) begin
            set_idle();
            ex_valid = 1; jmp = 1; pc_target = DW'(n * 2);
            tick();
            set_idle();
            tick();
            if (n == 15) chk("wrap.cnt4_15", c4_taken_cnt, 15);
        end
        chk("wrap.cnt4_0", c4_taken_cnt, 0);
        chk("wrap.cnt16", taken_cnt, 16);
        check_model("wrap");

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            set_idle();
            ex_valid   = ($urandom_range(3) != 0);
            mem_stall  = ($urandom_range(4) == 0);
            case ($urandom_range(3))
                0: branch = 1;
                1: jmp = 1;
                default: ;
            endcase
            link       = jmp && $urandom_range(1);
            mem_rd     = ($urandom_range(3) == 0);
            mem_wr     = !mem_rd && ($urandom_range(3) == 0);
            reg_wr     = $urandom_range(1);
            dest_reg   = 3'($urandom);
            alu_result = 16'($urandom);
            pc_target  = 16'($urandom);
            pc_plus_2  = 16'($urandom);
            store_data = 16'($urandom);
            tick();
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
